// File: rtl/memory_access_beta.sv
// Memory stage of the beta pipe: one execute op per handshake, drives the data bus
// for loads/stores, formats load data and raises address-error exceptions.
module memory_access_beta (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [3:0]  mem_op,
  input  logic [4:0]  in_reg_dest,
  input  logic        in_write_en,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        out_valid,
  output logic [31:0] result,
  output logic [4:0]  reg_dest,
  output logic        write_en,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] bad_vaddr
);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
    OP_LW   = 4'd5, OP_SB = 4'd6, OP_SH  = 4'd7, OP_SW = 4'd8
  } mem_op_e;

  typedef enum logic {IDLE, WAIT_ACK} state_e;

  state_e      state;
  logic [3:0]  pend_op;
  logic [4:0]  pend_dest;
  logic        pend_we;
  logic        pend_flushed;

  logic        accept;
  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready & ~flush;

  // Decode of the incoming op: access class, alignment and store lane placement.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    wstrb_c    = 4'b0000;
    wdata_c    = store_data;
    case (mem_op)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin
        is_load    = 1'b1;
        misaligned = alu_result[0];
      end
      OP_LW: begin
        is_load    = 1'b1;
        misaligned = |alu_result[1:0];
      end
      OP_SB: begin
        is_store = 1'b1;
        wstrb_c  = 4'b0001 << alu_result[1:0];
        wdata_c  = {4{store_data[7:0]}};
      end
      OP_SH: begin
        is_store   = 1'b1;
        misaligned = alu_result[0];
        wstrb_c    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{store_data[15:0]}};
      end
      OP_SW: begin
        is_store   = 1'b1;
        misaligned = |alu_result[1:0];
        wstrb_c    = 4'b1111;
      end
      default: ;
    endcase
  end

  // Little-endian lane pick from the held bus address, then sign/zero extension.
  always_comb begin
    case (dbus_addr[1:0])
      2'd0:    ld_byte = dbus_rdata[7:0];
      2'd1:    ld_byte = dbus_rdata[15:8];
      2'd2:    ld_byte = dbus_rdata[23:16];
      default: ld_byte = dbus_rdata[31:24];
    endcase
    ld_half = dbus_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (pend_op)
      OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_data = {24'd0, ld_byte};
      OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_data = {16'd0, ld_half};
      default: load_data = dbus_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pend_op      <= 4'd0;
      pend_dest    <= 5'd0;
      pend_we      <= 1'b0;
      pend_flushed <= 1'b0;
      dbus_req     <= 1'b0;
      dbus_we      <= 1'b0;
      dbus_wstrb   <= 4'b0000;
      dbus_addr    <= 32'd0;
      dbus_wdata   <= 32'd0;
      out_valid    <= 1'b0;
      result       <= 32'd0;
      reg_dest     <= 5'd0;
      write_en     <= 1'b0;
      exc_adel     <= 1'b0;
      exc_ades     <= 1'b0;
      bad_vaddr    <= 32'd0;
    end else begin
      out_valid <= 1'b0;
      write_en  <= 1'b0;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if ((is_load | is_store) & misaligned) begin
              out_valid <= 1'b1;
              exc_adel  <= is_load;
              exc_ades  <= is_store;
              bad_vaddr <= alu_result;
            end else if (is_load | is_store) begin
              dbus_req     <= 1'b1;
              dbus_we      <= is_store;
              dbus_wstrb   <= is_store ? wstrb_c : 4'b0000;
              dbus_addr    <= alu_result;
              dbus_wdata   <= is_store ? wdata_c : 32'd0;
              pend_op      <= mem_op;
              pend_dest    <= in_reg_dest;
              pend_we      <= is_load & in_write_en & (in_reg_dest != 5'd0);
              pend_flushed <= 1'b0;
              state        <= WAIT_ACK;
            end else begin
              out_valid <= 1'b1;
              result    <= alu_result;
              reg_dest  <= in_reg_dest;
              write_en  <= in_write_en & (in_reg_dest != 5'd0);
            end
          end
        end
        WAIT_ACK: begin
          // A squash never aborts the bus transfer; it only suppresses the completion.
          if (dbus_ack) begin
            state     <= IDLE;
            dbus_req  <= 1'b0;
            dbus_we   <= 1'b0;
            out_valid <= ~(pend_flushed | flush);
            write_en  <= pend_we & ~(pend_flushed | flush);
            reg_dest  <= pend_dest;
            if (!dbus_we) result <= load_data;
          end else if (flush) begin
            pend_flushed <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_beta.sv
// Self-checking bench for memory_access_beta: directed corner cases followed by
// randomized ops compared against an arithmetic reference model of the stage.
module tb_memory_access_beta;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic [3:0]  mem_op = '0;
  logic [4:0]  in_reg_dest = '0;
  logic        in_write_en = 1'b0;
  logic        dbus_req, dbus_we;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_addr, dbus_wdata;
  logic        dbus_ack = 1'b0;
  logic [31:0] dbus_rdata = '0;
  logic        out_valid;
  logic [31:0] result;
  logic [4:0]  reg_dest;
  logic        write_en, exc_adel, exc_ades;
  logic [31:0] bad_vaddr;

  int vectors = 0;
  int miscompares = 0;

  memory_access_beta dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .mem_op(mem_op),
    .in_reg_dest(in_reg_dest), .in_write_en(in_write_en),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_wstrb(dbus_wstrb),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .out_valid(out_valid), .result(result),
    .reg_dest(reg_dest), .write_en(write_en), .exc_adel(exc_adel),
    .exc_ades(exc_ades), .bad_vaddr(bad_vaddr)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit          bus;
    bit          we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    bit          valid;
    logic [31:0] result;
    bit          wen;
    bit          adel;
    bit          ades;
  } exp_t;

  // Reference model: what the stage must produce for one op, from size/sign rules.
  function automatic exp_t model(int op, logic [31:0] addr, logic [31:0] sdata,
                                 logic [31:0] rdata, logic [4:0] dest, bit we, bit discard);
    exp_t   e;
    int     size, off;
    bit     ld, sgn;
    longint mask, v;
    e = '{bus: 0, we: 0, wstrb: 4'd0, wdata: 32'd0, valid: 0, result: 32'd0,
          wen: 0, adel: 0, ades: 0};
    if (op < 1 || op > 8) begin
      e.valid  = 1;
      e.result = addr;
      e.wen    = we && (dest != 0);
      return e;
    end
    ld   = (op <= 5);
    sgn  = (op == 1 || op == 3);
    size = (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : 4;
    off  = int'(addr % 4);
    if ((addr % size) != 0) begin
      e.valid = 1;
      e.adel  = ld;
      e.ades  = !ld;
      return e;
    end
    e.bus   = 1;
    e.we    = !ld;
    e.valid = !discard;
    if (!ld) begin
      e.wstrb = 4'(((1 << size) - 1) << off);
      e.wdata = (size == 1) ? sdata[7:0] * 32'h0101_0101 :
                (size == 2) ? sdata[15:0] * 32'h0001_0001 : sdata;
    end else begin
      mask = (64'd1 << (8 * size)) - 1;
      v    = (longint'(rdata) >> (8 * off)) & mask;
      if (sgn && ((v >> (8 * size - 1)) & 1) == 1) v = v | ~mask;
      e.result = 32'(v);
      e.wen    = we && (dest != 0) && !discard;
    end
    return e;
  endfunction

  // Issues one op at a negedge and follows it to completion; ends on a negedge.
  // flush_at >= 0 asserts flush in that wait cycle (== delay means with the ack).
  task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input logic [4:0] dest, input bit we,
                        input int delay, input int flush_at);
    exp_t e;
    e = model(op, addr, sdata, rdata, dest, we, flush_at >= 0);
    check("in_ready_before", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    mem_op      = 4'(op);
    alu_result  = addr;
    store_data  = sdata;
    in_reg_dest = dest;
    in_write_en = we;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    if (!e.bus) begin
      check("no_req", 32'(dbus_req), 32'd0);
      check("out_valid", 32'(out_valid), 32'(e.valid));
      check("write_en", 32'(write_en), 32'(e.wen));
      check("exc_adel", 32'(exc_adel), 32'(e.adel));
      check("exc_ades", 32'(exc_ades), 32'(e.ades));
      if (e.adel || e.ades) check("bad_vaddr", bad_vaddr, addr);
      else begin
        check("alu_result", result, e.result);
        check("alu_dest", 32'(reg_dest), 32'(dest));
      end
    end else begin
      for (int k = 0; k <= delay; k++) begin
        check("req_held", 32'(dbus_req), 32'd1);
        check("bus_we", 32'(dbus_we), 32'(e.we));
        check("bus_wstrb", 32'(dbus_wstrb), 32'(e.wstrb));
        check("bus_addr", dbus_addr, addr);
        if (e.we) check("bus_wdata", dbus_wdata, e.wdata);
        check("wait_ready", 32'(in_ready), 32'd0);
        check("wait_valid", 32'(out_valid), 32'd0);
        dbus_ack   = (k == delay);
        dbus_rdata = (k == delay) ? rdata : $urandom;
        flush      = (k == flush_at);
        @(posedge clk);
        #1;
        dbus_ack = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
      end
      check("done_req", 32'(dbus_req), 32'd0);
      check("done_ready", 32'(in_ready), 32'd1);
      check("done_valid", 32'(out_valid), 32'(e.valid));
      check("done_wen", 32'(write_en), 32'(e.wen));
      check("done_exc", 32'({exc_adel, exc_ades}), 32'd0);
      if (e.valid && !e.we) begin
        check("load_result", result, e.result);
        check("load_dest", 32'(reg_dest), 32'(dest));
      end
    end
  endtask

  task automatic idle_flush();
    in_valid   = 1'b1;
    mem_op     = 4'($urandom_range(0, 8));
    alu_result = $urandom & 32'hFFFF_FFFC;
    flush      = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    check("idle_flush_valid", 32'(out_valid), 32'd0);
    check("idle_flush_req", 32'(dbus_req), 32'd0);
    check("idle_flush_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic stray_ack();
    dbus_ack   = 1'b1;
    dbus_rdata = $urandom;
    @(posedge clk);
    #1 dbus_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_valid", 32'(out_valid), 32'd0);
    check("stray_ack_wen", 32'(write_en), 32'd0);
    check("stray_ack_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic reset_mid_wait();
    in_valid    = 1'b1;
    mem_op      = 4'd5;
    alu_result  = 32'h0000_5000;
    in_reg_dest = 5'd3;
    in_write_en = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_req", 32'(dbus_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_req", 32'(dbus_req), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_addr", dbus_addr, 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dbus_ack = 1'b1;
    @(posedge clk);
    #1 dbus_ack = 1'b0;
    @(negedge clk);
    check("rst_lost_valid", 32'(out_valid), 32'd0);
    check("rst_after_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int op, delay, flush_at;
    logic [31:0] addr;
    #3;
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_req", 32'(dbus_req), 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op(0, 32'h1234_5678, 32'd0, 32'd0, 5'd5, 1'b1, 0, -1);
    run_op(1, 32'h0000_1003, 32'd0, 32'h80FF_0000, 5'd7, 1'b1, 3, -1);
    run_op(7, 32'h0000_2002, 32'h0000_BEEF, 32'd0, 5'd9, 1'b1, 1, -1);
    run_op(5, 32'h0000_3001, 32'd0, 32'd0, 5'd4, 1'b1, 0, -1);
    run_op(8, 32'h0000_3002, 32'h1111_2222, 32'd0, 5'd0, 1'b0, 0, -1);
    run_op(5, 32'h0000_4000, 32'd0, 32'hCAFE_F00D, 5'd6, 1'b1, 2, 0);
    run_op(5, 32'h0000_4004, 32'd0, 32'hCAFE_F00D, 5'd6, 1'b1, 1, 1);
    run_op(5, 32'h0000_4008, 32'd0, 32'hDEAD_BEEF, 5'd0, 1'b1, 0, -1);
    run_op(4, 32'h0000_400A, 32'd0, 32'h8765_4321, 5'd2, 1'b1, 0, -1);
    run_op(6, 32'h0000_4001, 32'h0000_00A5, 32'd0, 5'd2, 1'b1, 0, -1);
    run_op(12, 32'h0000_0003, 32'd0, 32'd0, 5'd0, 1'b1, 0, -1);
    idle_flush();
    stray_ack();
    reset_mid_wait();

    for (int n = 0; n < 300; n++) begin
      op    = $urandom_range(0, 15);
      addr  = $urandom;
      delay = $urandom_range(0, 3);
      flush_at = ($urandom_range(0, 3) == 0 && op >= 1 && op <= 8) ? $urandom_range(0, delay) : -1;
      run_op(op, addr, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom),
             delay, flush_at);
      case ($urandom_range(0, 9))
        0: idle_flush();
        1: stray_ack();
        default: ;
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
